// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction field bounds,
// default halt/NOP encodings and the fetch FSM state type.
package if_fetch_pkg;

  localparam int unsigned DEF_PC_W = 32;
  localparam int unsigned INST_W   = 32;
  localparam int unsigned OPC_MSB  = 0;
  localparam int unsigned OPC_LSB  = 5;
  localparam int unsigned OPC_W    = OPC_LSB - OPC_MSB + 1;

  localparam logic [0:OPC_W-1]  DEF_HALT_OP  = 6'b000001;
  localparam logic [0:INST_W-1] DEF_NOP_INST = 32'h0000_0000;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter with hold / branch-target / sequential-increment next-PC selection.
// Branch targets are 16 bits and zero-extended, clearing the upper PC bits.
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter int unsigned      PC_W     = DEF_PC_W,
  parameter int unsigned      PC_INC   = 4,
  parameter logic [0:PC_W-1]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_tgt,
  input  logic            incr,
  input  logic [0:15]     tgt,
  output logic [0:PC_W-1] pc
);

  logic [0:PC_W-1] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_tgt) begin
      pc_d = PC_W'(tgt);
    end else if (incr) begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, IF/ID pipeline register and RUN/HALT fetch FSM.
// Define IF_FETCH_PERF_CNT_EN to add fetch and flush performance counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       PC_W     = DEF_PC_W,
  parameter int unsigned       PC_INC   = 4,
  parameter logic [0:PC_W-1]   RESET_PC = '0,
  parameter logic [0:OPC_W-1]  HALT_OP  = DEF_HALT_OP,
  parameter logic [0:INST_W-1] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ID_br_ctrl,
  input  logic [0:15]       ID_imm_addr,
  input  logic              imem_rdy,
  input  logic [0:INST_W-1] imem_data,
  output logic [0:PC_W-1]   imem_addr,
  output logic              imem_en,
  output logic [0:INST_W-1] IF_ID_inst,
  output logic [0:PC_W-1]   IF_ID_pc,
  output logic              IF_ID_valid,
  output logic              IF_halted
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [0:31]       perf_fetch_cnt,
  output logic [0:31]       perf_flush_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [0:INST_W-1] inst_q, inst_d;
  logic [0:PC_W-1]   id_pc_q, id_pc_d;
  logic              valid_q, valid_d;
  logic [0:PC_W-1]   pc;
  logic              run, flush, fetch;

  // Stall dominates: decode operands are stale, so a branch under stall is ignored.
  assign run   = (state_q == StRun);
  assign flush = run && !stall && ID_br_ctrl;
  assign fetch = run && !stall && !ID_br_ctrl && imem_rdy;

  if_pc_reg #(
    .PC_W     (PC_W),
    .PC_INC   (PC_INC),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load_tgt (flush),
    .incr     (fetch),
    .tgt      (ID_imm_addr),
    .pc       (pc)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    if (fetch && (imem_data[OPC_MSB:OPC_LSB] == HALT_OP)) begin
      state_d = StHalt;
    end
    if (!stall) begin
      if (fetch) begin
        inst_d  = imem_data;
        id_pc_d = pc;
        valid_d = 1'b1;
      end else begin
        // Flush, bubble and halted edges all inject a NOP.
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      inst_q  <= NOP_INST;
      id_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc;
  assign imem_en     = run;
  assign IF_ID_inst  = inst_q;
  assign IF_ID_pc    = id_pc_q;
  assign IF_ID_valid = valid_q;
  assign IF_halted   = (state_q == StHalt);

`ifdef IF_FETCH_PERF_CNT_EN
  logic [0:31] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC, issues asynchronous-read addresses to instruction memory, and holds the IF/ID pipeline register that drives the decode stage's ID_inst input.
- Consumes ID_br_ctrl and ID_imm_addr from decode for taken branches/jumps, and the hazard-unit stall.
- Stops fetching after a HALT opcode.

Parameters:
- PC_W, 32, PC and instruction-memory address width (bit 0 = MSB).
- PC_INC, 4, byte increment per sequential fetch.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 6'b000001, opcode in inst[0:5] that halts fetch.
- NOP_INST, 32'h0000_0000, instruction injected on bubble/flush.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; hold PC and IF/ID.
- ID_br_ctrl  in  1  taken branch/jump resolved in decode this cycle.
- ID_imm_addr  in  [0:15]  branch target from decode.
- imem_rdy  in  1  instruction memory has valid data for imem_addr this cycle.
- imem_data  in  [0:31]  instruction read combinationally at imem_addr.
- imem_addr  out  [0:PC_W-1]  fetch address, equals pc_q.
- imem_en  out  1  fetch request, high only in RUN.
- IF_ID_inst  out  [0:31]  registered instruction to decode (ID_inst).
- IF_ID_pc  out  [0:PC_W-1]  registered PC of IF_ID_inst.
- IF_ID_valid  out  1  IF_ID_inst is a real fetched instruction.
- IF_halted  out  1  fetch stopped by HALT_OP.

Behaviour:
- Reset (async, any cycle, including mid-stall or while halted):
  - pc_q = RESET_PC
  - IF_ID_inst = NOP_INST, IF_ID_pc = 0, IF_ID_valid = 0
  - state = RUN, IF_halted = 0
- FSM states: RUN, HALT.
  - RUN -> HALT on an edge where a real fetch is accepted (see priority case 3 below) and imem_data[0:5] == HALT_OP.
  - HALT exits only on reset.
- imem_addr = pc_q, combinational. imem_en = (state == RUN).
- Per-edge priority in RUN:
  1. stall=1: pc_q and all IF/ID registers hold. ID_br_ctrl is ignored (decode operands are stale during a stall).
  2. ID_br_ctrl=1 (stall=0):
     - pc_q <= zero-extend(ID_imm_addr) to PC_W.
     - IF_ID_inst <= NOP_INST, IF_ID_valid <= 0 (flush the delay-slot fetch).
     - No halt detection on the discarded fetch.
  3. imem_rdy=1:
     - IF_ID_inst <= imem_data, IF_ID_pc <= pc_q, IF_ID_valid <= 1
     - pc_q <= pc_q + PC_INC, wrapping modulo 2^PC_W.
  4. imem_rdy=0: pc_q holds. IF_ID_inst <= NOP_INST, IF_ID_valid <= 0 (bubble).
- Latency: instruction at PC X appears on IF_ID_inst one edge after pc_q == X with imem_rdy=1.
- HALT state:
  - pc_q frozen.
  - The halt instruction is captured normally on the entry edge.
  - Subsequent non-stalled edges load NOP_INST with IF_ID_valid = 0. A stall in HALT still holds IF/ID.
  - ID_br_ctrl is ignored.
  - IF_halted = 1.
- Branch target wrap: ID_imm_addr covers only the low 64 KiB. Upper PC bits clear on a branch.

Optional Feature:
- Macro IF_FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt [0:31] and perf_flush_cnt [0:31]. Both reset to 0, increment on case-3 edges and case-2 edges respectively, and wrap at 2^32.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Decomposition:
- Shared cpu package holds:
  - PC_W, INST_W = 32, OPCODE field bounds [0:5]
  - HALT_OP, NOP_INST
  - FSM state encoding (RUN = 1'b0, HALT = 1'b1)
- One natural sub-module, if_pc_reg: PC register with next-PC mux (hold/target/increment) and async reset.
- IF/ID register and FSM stay in if_fetch.

Test Plan:
- Reset release with imem_rdy=1 and memory word at addr 0 = 32'h1234_5678 -> imem_addr 0, 4, 8 on successive cycles; after first edge IF_ID_inst = 32'h1234_5678, IF_ID_pc = 0, IF_ID_valid = 1.
- At pc_q = 8, assert ID_br_ctrl=1, ID_imm_addr = 16'h0040 -> next cycle pc_q = 32'h40, IF_ID_inst = NOP_INST, IF_ID_valid = 0; the following edge fetches from 0x40.
- Assert stall=1 and ID_br_ctrl=1 together for 2 cycles at pc_q = 0x10 -> pc_q stays 0x10, IF_ID unchanged; on release with br_ctrl=0, fetch resumes at 0x10.
- imem_rdy=0 for 3 cycles at pc_q = 0x20 -> 3 bubbles (IF_ID_valid = 0, NOP_INST), pc_q stays 0x20; then one valid fetch of 0x20.
- Word at 0x30 has opcode HALT_OP -> IF_ID_inst = that word with valid = 1, then IF_halted = 1, imem_en = 0, pc_q = 0x34 frozen, NOPs forever.
- Assert reset mid-HALT, and separately with pc_q = 32'hFFFF_FFFC -> reset returns all outputs to reset values. Without reset, a sequential fetch from 32'hFFFF_FFFC wraps pc_q to 0.
